// File: rtl/btn_sw_debounce_if.sv
// Bundle of raw board inputs and conditioned outputs for btn_sw_debounce.
// master: board/stimulus side (drives raw levels, observes results).
// slave : debouncer side.
interface btn_sw_debounce_if;
   logic [3:0] btn_raw;
   logic [7:0] sw_raw;
   logic [3:0] btn_out;
   logic [7:0] sw_out;
   logic [3:0] btn_pulse;

   modport master (
      output btn_raw,
      output sw_raw,
      input  btn_out,
      input  sw_out,
      input  btn_pulse
   );

   modport slave (
      input  btn_raw,
      input  sw_raw,
      output btn_out,
      output sw_out,
      output btn_pulse
   );
endinterface

// File: rtl/btn_sw_debounce.sv
// Button / slide-switch conditioner.
// Each of the 12 bits (buttons in [3:0], switches in [11:4]) runs through a
// 2-flop synchroniser and a stability counter. A new level is accepted only
// after the synchronised input has differed from the accepted level for
// DB_CYCLES consecutive clocks. Buttons also get a one-clock press pulse.
module btn_sw_debounce #(
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16,
   parameter int BTN_INV   = 0
) (
   input logic             clk,
   input logic             rst,
   btn_sw_debounce_if.slave bus
);

   localparam int NB = 12;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [3:0]    btn_in;
   logic [NB-1:0] raw_in;
   logic [NB-1:0] sync1;
   logic [NB-1:0] sync2;
   logic [NB-1:0] stable;
   logic [NB-1:0] accept;
   logic [3:0]    pulse;

   // Active-low buttons are flipped before synchronisation so that
   // everything downstream sees 1 = pressed.
   assign btn_in = (BTN_INV != 0) ? ~bus.btn_raw : bus.btn_raw;
   assign raw_in = {bus.sw_raw, btn_in};

   // Two-flop synchroniser for all asynchronous board inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_bit
         logic [CNT_W-1:0] cnt;
         logic             level;

         // The window closes on the clock where the counter is already at
         // its top value and the input still disagrees.
         assign accept[gi] = (sync2[gi] != level) && (cnt == CNT_MAX);
         assign stable[gi] = level;

         // Stability counter: any agreement with the accepted level
         // clears it, so a bounce restarts the whole window. It never
         // passes CNT_MAX because reaching it either accepts or clears.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt   <= '0;
               level <= 1'b0;
            end else if (sync2[gi] == level) begin
               cnt <= '0;
            end else if (accept[gi]) begin
               level <= sync2[gi];
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   endgenerate

   // Press pulse: registered alongside the level, so it is high for
   // exactly the cycle after a button is accepted as pressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse <= '0;
      end else begin
         pulse <= accept[3:0] & sync2[3:0];
      end
   end

   assign bus.btn_out   = stable[3:0];
   assign bus.sw_out    = stable[11:4];
   assign bus.btn_pulse = pulse;

endmodule

// File: tb/tb_btn_sw_debounce.sv
// Self-checking bench for btn_sw_debounce.
// Two instances share the same raw stimulus: one with BTN_INV=0, one with
// BTN_INV=1. A window-based reference model predicts both every clock; the
// prediction goes into a scoreboard queue and a monitor compares at negedge.
module tb_btn_sw_debounce;

   localparam int DB = 4;

   logic clk;
   logic rst;
   logic [3:0] btn_v;
   logic [7:0] sw_v;

   btn_sw_debounce_if bus_a ();
   btn_sw_debounce_if bus_b ();

   assign bus_a.btn_raw = btn_v;
   assign bus_a.sw_raw  = sw_v;
   assign bus_b.btn_raw = btn_v;
   assign bus_b.sw_raw  = sw_v;

   btn_sw_debounce #(.DB_CYCLES(DB), .CNT_W(3), .BTN_INV(0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   btn_sw_debounce #(.DB_CYCLES(DB), .CNT_W(3), .BTN_INV(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // Expected word: {pulse_b, level_b[11:0], pulse_a, level_a[11:0]},
   // level layout {sw[7:0], btn[3:0]}.
   logic [31:0] sb [$];

   // Reference model: history of sampled raw values (most recent first) and
   // the accepted level. A bit flips when the DB most recent values that
   // have made it through the two synchroniser stages all disagree with
   // the accepted level.
   logic [11:0] hist [2][DB+2];
   logic [11:0] stab [2];
   logic [3:0]  pls  [2];

   function automatic logic [11:0] eff_raw(input int d);
      return {sw_v, (d == 1) ? ~btn_v : btn_v};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int j = 0; j < DB + 2; j++) hist[d][j] = '0;
         stab[d] = '0;
         pls[d]  = '0;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else begin
         for (int d = 0; d < 2; d++) begin
            for (int j = DB + 1; j > 0; j--) hist[d][j] = hist[d][j-1];
            hist[d][0] = eff_raw(d);
            pls[d] = '0;
            for (int b = 0; b < 12; b++) begin
               logic all_diff;
               all_diff = 1'b1;
               for (int j = 2; j < DB + 2; j++)
                  if (hist[d][j][b] == stab[d][b]) all_diff = 1'b0;
               if (all_diff) begin
                  stab[d][b] = ~stab[d][b];
                  if (b < 4 && stab[d][b]) pls[d][b] = 1'b1;
               end
            end
         end
      end
   endtask

   // One clock of stimulus: model the edge, then drive the next inputs and
   // queue what the outputs must show at the following negedge.
   task automatic cyc(input logic r, input logic [3:0] b, input logic [7:0] s);
      @(posedge clk);
      model_edge();
      cycle++;
      #1;
      rst   = r;
      btn_v = b;
      sw_v  = s;
      if (r) model_reset();
      sb.push_back({pls[1], stab[1], pls[0], stab[0]});
   endtask

   task automatic hold(input int n, input logic r, input logic [3:0] b, input logic [7:0] s);
      for (int i = 0; i < n; i++) cyc(r, b, s);
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
      end
   endtask

   // Monitor: outputs are presented every clock; compare each queued prediction.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         logic [31:0] e;
         e = sb.pop_front();
         chk("a.btn_out",   {8'h0, bus_a.btn_out},   {8'h0, e[3:0]});
         chk("a.sw_out",    {4'h0, bus_a.sw_out},    {4'h0, e[11:4]});
         chk("a.btn_pulse", {8'h0, bus_a.btn_pulse}, {8'h0, e[15:12]});
         chk("b.btn_out",   {8'h0, bus_b.btn_out},   {8'h0, e[19:16]});
         chk("b.sw_out",    {4'h0, bus_b.sw_out},    {4'h0, e[27:20]});
         chk("b.btn_pulse", {8'h0, bus_b.btn_pulse}, {8'h0, e[31:28]});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rb;
      logic [7:0] rs;
      int den;
      rst   = 1'b1;
      btn_v = '0;
      sw_v  = '0;
      model_reset();

      hold(3, 1'b1, 4'h0, 8'h00);
      $display("phase reset done, cycle %0d", cycle);

      // Single button press held.
      hold(10, 1'b0, 4'h1, 8'h00);
      $display("phase btn0 press done, cycle %0d", cycle);

      // Switch pattern held steady.
      hold(10, 1'b0, 4'h1, 8'hA5);
      $display("phase sw A5 done, cycle %0d", cycle);

      // Short glitch on btn1 (3 clocks).
      hold(3, 1'b0, 4'h3, 8'hA5);
      hold(10, 1'b0, 4'h1, 8'hA5);
      $display("phase btn1 glitch done, cycle %0d", cycle);

      // Bounce on btn2, then hold, then release.
      cyc(1'b0, 4'h5, 8'hA5);
      cyc(1'b0, 4'h1, 8'hA5);
      cyc(1'b0, 4'h5, 8'hA5);
      cyc(1'b0, 4'h1, 8'hA5);
      hold(10, 1'b0, 4'h5, 8'hA5);
      hold(10, 1'b0, 4'h1, 8'hA5);
      $display("phase btn2 bounce done, cycle %0d", cycle);

      // Reset in the middle of btn3's window, then restart with it held.
      hold(4, 1'b0, 4'h9, 8'hA5);
      hold(2, 1'b1, 4'h9, 8'hA5);
      hold(10, 1'b0, 4'h9, 8'hA5);
      $display("phase mid-count reset done, cycle %0d", cycle);

      // Pattern that the inverted-button instance reads as 4'h1.
      hold(10, 1'b0, 4'hE, 8'h00);
      $display("phase inverted buttons done, cycle %0d", cycle);

      // Randomised bouncy traffic alternating calm and noisy stretches.
      rb  = 4'hE;
      rs  = 8'h00;
      den = 40;
      for (int i = 0; i < 320; i++) begin
         if (i % 25 == 0) den = ($urandom_range(0, 1) == 0) ? 40 : 3;
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, den - 1) == 0) rb[b] = ~rb[b];
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, den - 1) == 0) rs[b] = ~rs[b];
         if ($urandom_range(0, 119) == 0) hold(2, 1'b1, rb, rs);
         else cyc(1'b0, rb, rs);
      end
      $display("phase random done, cycle %0d", cycle);

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
